// File: rtl/tape_frame_reader.sv
// tape_frame_reader
//   Recovers framed words from a punched-tape reader. The clock track marks
//   each data sample (either transition), the frame track closes a word
//   (either transition). Good words are queued in a small show-ahead FIFO.
//
//   Optional feature macro: TAPE_READER_DEBOUNCE_EN
//     defined   -> clock and frame tracks pass through a DEBOUNCE_CYC filter
//     undefined -> filtered track equals the registered synchronised value
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   clk_track         : sprocket track, each transition = one sample
//   data_track        : DATA_TRACKS data hole sensors
//   frame_track       : frame marker, each transition ends a word
//   out_data/out_valid: head of FIFO (show-ahead) / FIFO non-empty
//   out_ready         : consumer pops when out_valid && out_ready
//   frame_err         : one-cycle pulse, frame closed with wrong bit count
//   overflow          : sticky, good word dropped on full FIFO
//   fifo_count        : number of FIFO entries
module tape_frame_reader #(
  parameter int DATA_TRACKS  = 1,
  parameter int WORD_BITS    = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clk_track,
  input  logic [DATA_TRACKS-1:0]        data_track,
  input  logic                          frame_track,
  output logic [WORD_BITS-1:0]          out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CNT_W  = $clog2(WORD_BITS + DATA_TRACKS + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;

  // Bit counter increment that sticks at WORD_BITS+DATA_TRACKS so an
  // over-long frame can never wrap back to a "good" count.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c);
    if (c >= CNT_W'(WORD_BITS))
      return CNT_W'(WORD_BITS + DATA_TRACKS);
    else
      return c + CNT_W'(DATA_TRACKS);
  endfunction

  // ---- stage p0/p1: two-flop synchronisers, idle level is 1 ----
  logic                   clk_p0, clk_p1, frm_p0, frm_p1;
  logic [DATA_TRACKS-1:0] dat_p0, dat_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_p0 <= 1'b1;
      clk_p1 <= 1'b1;
      frm_p0 <= 1'b1;
      frm_p1 <= 1'b1;
      dat_p0 <= '1;
      dat_p1 <= '1;
    end else begin
      clk_p0 <= clk_track;
      clk_p1 <= clk_p0;
      frm_p0 <= frame_track;
      frm_p1 <= frm_p0;
      dat_p0 <= data_track;
      dat_p1 <= dat_p0;
    end
  end

  // ---- stage p2: filtered track values ----
  logic clk_filt_p2, frm_filt_p2;

`ifdef TAPE_READER_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  logic [DB_W-1:0] clk_db, frm_db;

  // A 1-bit track can only disagree with the filtered value in one way, so
  // the candidate is implicit: count consecutive disagreeing samples and
  // accept the new level once DEBOUNCE_CYC of them have been seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_filt_p2 <= 1'b1;
      frm_filt_p2 <= 1'b1;
      clk_db      <= '0;
      frm_db      <= '0;
    end else begin
      if (clk_p1 == clk_filt_p2) begin
        clk_db <= '0;
      end else if (clk_db == DB_W'(DEBOUNCE_CYC)) begin
        clk_filt_p2 <= clk_p1;
        clk_db      <= '0;
      end else begin
        clk_db <= clk_db + DB_W'(1);
      end
      if (frm_p1 == frm_filt_p2) begin
        frm_db <= '0;
      end else if (frm_db == DB_W'(DEBOUNCE_CYC)) begin
        frm_filt_p2 <= frm_p1;
        frm_db      <= '0;
      end else begin
        frm_db <= frm_db + DB_W'(1);
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_filt_p2 <= 1'b1;
      frm_filt_p2 <= 1'b1;
    end else begin
      clk_filt_p2 <= clk_p1;
      frm_filt_p2 <= frm_p1;
    end
  end
`endif

  // ---- stage p3: previous filtered values, edge detection ----
  logic clk_prev_p3, frm_prev_p3;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_prev_p3 <= 1'b1;
      frm_prev_p3 <= 1'b1;
    end else begin
      clk_prev_p3 <= clk_filt_p2;
      frm_prev_p3 <= frm_filt_p2;
    end
  end

  logic clk_edge, frm_edge;
  assign clk_edge = clk_filt_p2 ^ clk_prev_p3;
  assign frm_edge = frm_filt_p2 ^ frm_prev_p3;

  // ---- word assembly: shift applies before the frame check ----
  logic [WORD_BITS-1:0] sr, sr_shift;
  logic [CNT_W-1:0]     bcnt, bcnt_shift;
  logic                 vld_p3, err_p3;

  assign sr_shift   = clk_edge ? ((sr << DATA_TRACKS) | WORD_BITS'(dat_p1)) : sr;
  assign bcnt_shift = clk_edge ? sat_add(bcnt) : bcnt;
  assign vld_p3     = frm_edge && (bcnt_shift == CNT_W'(WORD_BITS));
  assign err_p3     = frm_edge && (bcnt_shift != CNT_W'(WORD_BITS));

  always_ff @(posedge clk) begin
    if (rst) begin
      sr        <= '0;
      bcnt      <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= err_p3;
      if (frm_edge) begin
        sr   <= '0;
        bcnt <= '0;
      end else begin
        sr   <= sr_shift;
        bcnt <= bcnt_shift;
      end
    end
  end

  // ---- stage p4: output FIFO ----
  logic [WORD_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic                 full, pop, wr_en;

  assign full      = (fifo_count == FCNT_W'(FIFO_DEPTH));
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign wr_en     = vld_p3 && (!full || pop);
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= sr_shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + FCNT_W'(1);
        2'b01:   fifo_count <= fifo_count - FCNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (vld_p3 && !wr_en)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tape_frame_reader.sv
module tb_tape_frame_reader;

`ifdef TAPE_READER_DEBOUNCE_EN
  localparam int DB = 4;
`else
  localparam int DB = 0;
`endif
  localparam int LAT    = 3 + DB;
  localparam int SETTLE = DB + 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       ct1, ft1, rdy1;
  logic [0:0] d1;
  logic [7:0] od1;
  logic       ov1, fe1, of1;
  logic [2:0] cnt1;

  logic       ct2, ft2, rdy2;
  logic [1:0] d2;
  logic [7:0] od2;
  logic       ov2, fe2, of2;
  logic [2:0] cnt2;

  int n_chk = 0;
  int n_err = 0;
  int err_pulses = 0;
  int e0;

  always #5 clk = ~clk;

  tape_frame_reader dut1 (
    .clk(clk), .rst(rst), .clk_track(ct1), .data_track(d1), .frame_track(ft1),
    .out_data(od1), .out_valid(ov1), .out_ready(rdy1), .frame_err(fe1),
    .overflow(of1), .fifo_count(cnt1)
  );

  tape_frame_reader #(.DATA_TRACKS(2), .WORD_BITS(8)) dut2 (
    .clk(clk), .rst(rst), .clk_track(ct2), .data_track(d2), .frame_track(ft2),
    .out_data(od2), .out_valid(ov2), .out_ready(rdy2), .frame_err(fe2),
    .overflow(of2), .fifo_count(cnt2)
  );

  // Counts cycles during which frame_err is high on the first instance.
  always @(posedge clk) if (fe1) err_pulses++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; ct1 = 1'b1; ft1 = 1'b1; ct2 = 1'b1; ft2 = 1'b1;
    rdy1 = 1'b0; rdy2 = 1'b0; d1 = '0; d2 = '0;
    tick(3);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic clk_bit(input logic b);
    d1 = b;
    tick(2);
    ct1 = ~ct1;
    tick(SETTLE);
  endtask

  task automatic frame1();
    ft1 = ~ft1;
    tick(SETTLE);
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) clk_bit(w[i]);
    frame1();
  endtask

  task automatic pop1(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, ov1, 1'b1);
    chk({tag, "_data"}, od1, exp);
    rdy1 = 1'b1;
    tick(1);
    rdy1 = 1'b0;
  endtask

  task automatic clk_pair(input logic [1:0] p);
    d2 = p;
    tick(2);
    ct2 = ~ct2;
    tick(SETTLE);
  endtask

  initial begin
    do_reset();
    chk("rst_valid", ov1, 1'b0);
    chk("rst_count", cnt1, 3'd0);
    chk("rst_overflow", of1, 1'b0);
    chk("rst_frame_err", fe1, 1'b0);
    tick(SETTLE);
    chk("rst_no_edge_err", err_pulses, 0);

    // 10110010 then frame, with latency check on the frame toggle
    e0 = err_pulses;
    clk_bit(1); clk_bit(0); clk_bit(1); clk_bit(1);
    clk_bit(0); clk_bit(0); clk_bit(1); clk_bit(0);
    ft1 = ~ft1;
    tick(LAT);
    chk("lat_not_yet", ov1, 1'b0);
    tick(1);
    chk("lat_valid", ov1, 1'b1);
    tick(SETTLE);
    chk("b2_data", od1, 8'hB2);
    chk("b2_count", cnt1, 3'd1);
    chk("b2_no_err", err_pulses - e0, 0);
    pop1("b2_pop", 8'hB2);
    chk("b2_empty", cnt1, 3'd0);

    // 7 bits then frame: one-cycle error, nothing pushed
    e0 = err_pulses;
    for (int i = 0; i < 7; i++) clk_bit(i[0]);
    frame1();
    chk("short_err", err_pulses - e0, 1);
    chk("short_count", cnt1, 3'd0);

    // frame with zero bits
    e0 = err_pulses;
    frame1();
    chk("zero_err", err_pulses - e0, 1);
    chk("zero_count", cnt1, 3'd0);

    // 9 bits: counter saturates above WORD_BITS, frame rejected
    e0 = err_pulses;
    clk_bit(1);
    for (int i = 0; i < 8; i++) clk_bit(i[0]);
    frame1();
    chk("long_err", err_pulses - e0, 1);
    chk("long_count", cnt1, 3'd0);

    // overflow with out_ready low; write pointer starts at 1 so it wraps
    send_word(8'hA5); send_word(8'h3C); send_word(8'h0F);
    send_word(8'hF0); send_word(8'h99);
    chk("ovf_count", cnt1, 3'd4);
    chk("ovf_flag", of1, 1'b1);
    pop1("ovf_d0", 8'hA5);
    pop1("ovf_d1", 8'h3C);
    pop1("ovf_d2", 8'h0F);
    pop1("ovf_d3", 8'hF0);
    chk("ovf_drained", cnt1, 3'd0);
    chk("ovf_sticky", of1, 1'b1);
    do_reset();
    chk("ovf_cleared", of1, 1'b0);

    // full FIFO, push and pop on the same edge
    send_word(8'h11); send_word(8'h22); send_word(8'h33); send_word(8'h44);
    chk("full_count", cnt1, 3'd4);
    for (int i = 7; i >= 0; i--) clk_bit(8'h55 >> i);
    ft1 = ~ft1;
    tick(LAT);
    rdy1 = 1'b1;
    tick(1);
    rdy1 = 1'b0;
    chk("pp_count", cnt1, 3'd4);
    chk("pp_overflow", of1, 1'b0);
    tick(SETTLE);
    pop1("pp_d0", 8'h22);
    pop1("pp_d1", 8'h33);
    pop1("pp_d2", 8'h44);
    pop1("pp_d3", 8'h55);
    chk("pp_empty", cnt1, 3'd0);

    // reset mid-word with FIFO content, then mid-debounce
    send_word(8'h66);
    e0 = err_pulses;
    clk_bit(1); clk_bit(1); clk_bit(0); clk_bit(1);
    do_reset();
    chk("mid_count", cnt1, 3'd0);
    chk("mid_valid", ov1, 1'b0);
    ft1 = ~ft1;
    tick(1);
    do_reset();
    tick(SETTLE);
    chk("mid_no_err", err_pulses - e0, 0);
    send_word(8'h81);
    chk("mid_new_word", od1, 8'h81);
    chk("mid_new_count", cnt1, 3'd1);
    pop1("mid_pop", 8'h81);

`ifdef TAPE_READER_DEBOUNCE_EN
    // 3-cycle clock-track glitch must be ignored
    e0 = err_pulses;
    ct1 = ~ct1;
    tick(3);
    ct1 = ~ct1;
    tick(SETTLE);
    send_word(8'h5A);
    chk("glitch_no_err", err_pulses - e0, 0);
    chk("glitch_count", cnt1, 3'd1);
    pop1("glitch_word", 8'h5A);
`endif

    // two data tracks: 11,00,10,01 -> C9
    clk_pair(2'b11); clk_pair(2'b00); clk_pair(2'b10); clk_pair(2'b01);
    ft2 = ~ft2;
    tick(SETTLE);
    chk("dt2_valid", ov2, 1'b1);
    chk("dt2_data", od2, 8'hC9);
    chk("dt2_count", cnt2, 3'd1);
    chk("dt2_no_err", fe2 | of2, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
